demod_stream_proc: RTL and testbench
====================================

// Module: demod_stream_proc
// PURPOSE
//  Parametrised store-and-forward packet demodulator, successor of the fixed 16-QAM byte path.
//  Accepts one I/Q symbol per input beat and hard-decides BPSK/QPSK/16-QAM bits (mode latched per packet).
//  Packs bits MSB-first into bytes and buffers the whole packet.
//  Then streams it to the manager with byte count and last flag.
// PARAMETERS
//  SYM_W      8     symbol width; I = i_tdata[SYM_W-1:SYM_W/2], Q = lower half, both two's complement
//  OUT_DEPTH  2048  packet buffer depth in bytes (power of two)
//  SIZE_W     12    width of o_packet_size_in_bytes; must hold OUT_DEPTH
//  QAM_THR    4     16-QAM amplitude threshold, compared against |I|, |Q|
// PORTS
//  i_clk                   in   1       clock
//  i_rst                   in   1       synchronous active-high reset
//  i_tdata_valid           in   1       input symbol valid
//  i_tdata                 in   SYM_W   input symbol
//  i_tdata_last            in   1       last symbol of packet
//  i_mode                  in   2       00 BPSK, 01 QPSK, 10 16-QAM, 11 reserved (= QPSK)
//  o_tready                out  1       input ready
//  i_tmanager_ready        in   1       downstream ready
//  o_tanswer_ready         out  1       output byte valid
//  o_tanswer_data          out  8       output byte
//  o_tanswer_data_last     out  1       last output byte of packet
//  o_packet_size_in_bytes  out  SIZE_W  byte count of current output packet
// BEHAVIOUR
//  - Reset: state IDLE; o_tready=1; o_tanswer_ready=0, o_tanswer_data=0, o_tanswer_data_last=0, size=0.
//    Buffer pointers and bit packer are cleared. Reset mid-packet discards all buffered data.
//  - Handshakes: input beat on i_tdata_valid&o_tready; output beat on o_tanswer_ready&i_tmanager_ready.
//    Output data/last hold stable while i_tmanager_ready=0.
//  - FSM states:
//    IDLE -> RECV on the first input beat; i_mode is latched on that beat.
//    RECV -> FLUSH on the beat carrying i_tdata_last.
//    FLUSH (1 cycle): write any partial byte, zero-padded in the LSBs; freeze size.
//    PREP (1 cycle): prefetch RAM address 0.
//    SEND -> IDLE on the output beat carrying last.
//    o_tready=1 only in IDLE/RECV.
//    A last beat taken in IDLE counts as both first and last symbol (IDLE -> FLUSH).
//  - Latency: o_tanswer_ready rises on the 3rd rising edge after the edge that accepted i_tdata_last.
//  - Bit decisions (1 = negative): BPSK {sI}; QPSK {sI,sQ}; 16-QAM {sI, |I|>=QAM_THR, sQ, |Q|>=QAM_THR}.
//    |x| is computed at SYM_W/2+1 bits, so the most negative value has no overflow.
//  - Packing: bits shift in MSB-first. A byte is written when 8 bits accumulate; a symbol never straddles a write.
//  - Size: bytes written, including the padded byte. Valid and stable from FLUSH exit until SEND exit.
//    Minimum 1. o_tanswer_data_last=1 exactly on byte index size-1.
//  - Overflow: bytes beyond OUT_DEPTH are dropped and input stays ready. The packet is truncated to OUT_DEPTH.
//  - Simultaneous events: none across states, since input and output phases are exclusive.
//    i_mode changes mid-packet are ignored.
// CONFIGURATION
//  DEMOD_STATS_EN defined: adds outputs o_pkt_count[15:0] and o_drop_count[15:0].
//    o_pkt_count increments on each SEND->IDLE. o_drop_count increments per dropped overflow byte.
//    Both saturate at 16'hFFFF and reset to 0.
//  DEMOD_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  demod_stream_pkg: mode_e (MODE_BPSK/QPSK/QAM16), state_e (IDLE/RECV/FLUSH/PREP/SEND),
//    function bits_per_mode(mode_e).
//  Sub-module demod_stream_packer: symbol + mode in, 8-bit byte + byte_valid out, flush input.
//  The buffer RAM is inferred inline in the top.
// TESTING
//  1. QPSK symbols 0x1F,0xF1,0xFF,0x11 (last on 4th) -> one byte 0x6C, size 1, last=1.
//  2. 16-QAM 0x7C,0x21 (last) -> byte 0x70, size 1.
//  3. BPSK 0x80,0x10,0x90 (last) -> 0xA0 (padded), size 1; ready rises 3 edges after last.
//  4. OUT_DEPTH=4, QPSK 24 symbols -> 4 bytes out, size 4; with DEMOD_STATS_EN, drop_count=2.
//  5. Toggle i_tmanager_ready 1/0 each cycle during SEND -> data stable when low, no byte lost or duplicated,
//     o_tready=0 throughout; pkt_count increments by 1.
//  6. Assert i_rst in SEND after byte 1 of 3 -> next cycle all outputs 0, o_tready=1;
//     the following packet is output correctly.

Source files
------------

// File: rtl/demod_stream_pkg.sv
// demod_stream_pkg
//   Shared types and helpers for the demod_stream_proc packet demodulator.
//   mode_e        : modulation selected per packet (the reserved code 2'b11 maps to QPSK)
//   state_e       : top-level FSM states
//   to_mode()     : raw 2-bit mode input -> mode_e
//   bits_per_mode : number of hard-decided bits produced per symbol
package demod_stream_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'b00,
    MODE_QPSK  = 2'b01,
    MODE_QAM16 = 2'b10
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    FLUSH = 3'd2,
    PREP  = 3'd3,
    SEND  = 3'd4
  } state_e;

  function automatic mode_e to_mode(input logic [1:0] m);
    case (m)
      2'b00:   return MODE_BPSK;
      2'b10:   return MODE_QAM16;
      default: return MODE_QPSK;  // 2'b01 and the reserved 2'b11
    endcase
  endfunction

  function automatic logic [2:0] bits_per_mode(input mode_e m);
    case (m)
      MODE_BPSK:  return 3'd1;
      MODE_QAM16: return 3'd4;
      default:    return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/demod_stream_packer.sv
// demod_stream_packer
//   Hard-decides one I/Q symbol into 1, 2 or 4 bits and packs them MSB-first
//   into bytes. Because 8 is a multiple of every bits-per-symbol value, a
//   symbol never straddles two bytes.
//   The byte output is combinational from the accumulator and the incoming
//   symbol, so the completing symbol's byte can be written on the same edge
//   that accepts it; a flush emits the partial byte zero-padded in the LSBs.
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   sym_valid_i      symbol accepted this cycle
//   sym_i            I in upper half, Q in lower half, two's complement
//   mode_i           modulation for this symbol
//   flush_i          emit any partial byte and clear (never together with sym_valid_i)
//   byte_o           packed byte
//   byte_valid_o     byte_o must be stored this cycle
module demod_stream_packer
  import demod_stream_pkg::*;
#(
  parameter int SYM_W   = 8,
  parameter int QAM_THR = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sym_valid_i,
  input  logic [SYM_W-1:0] sym_i,
  input  mode_e            mode_i,
  input  logic             flush_i,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o
);

  localparam int H = SYM_W / 2;

  logic [H:0] i_ext, q_ext, abs_i, abs_q;
  logic       s_i, s_q, big_i, big_q;
  logic [3:0] sym_bits;
  logic [2:0] n_bits;
  logic [3:0] cnt_sum;
  logic [7:0] acc_shift;

  logic [7:0] acc_q;
  logic [3:0] cnt_q;

  // Magnitudes are formed one bit wider than a component so that the most
  // negative value (e.g. -8 for 4-bit halves) does not wrap.
  assign i_ext = {sym_i[SYM_W-1], sym_i[SYM_W-1:H]};
  assign q_ext = {sym_i[H-1], sym_i[H-1:0]};
  assign s_i   = i_ext[H];
  assign s_q   = q_ext[H];
  assign abs_i = s_i ? (~i_ext + (H+1)'(1)) : i_ext;
  assign abs_q = s_q ? (~q_ext + (H+1)'(1)) : q_ext;
  assign big_i = (abs_i >= (H+1)'(QAM_THR));
  assign big_q = (abs_q >= (H+1)'(QAM_THR));

  assign n_bits = bits_per_mode(mode_i);

  always_comb begin
    sym_bits = 4'b0000;
    case (mode_i)
      MODE_BPSK:  sym_bits = {3'b000, s_i};
      MODE_QAM16: sym_bits = {s_i, big_i, s_q, big_q};
      default:    sym_bits = {2'b00, s_i, s_q};
    endcase
  end

  assign cnt_sum   = cnt_q + {1'b0, n_bits};
  assign acc_shift = (acc_q << n_bits) | {4'b0000, sym_bits};

  assign byte_valid_o = (sym_valid_i && (cnt_sum == 4'd8)) || (flush_i && (cnt_q != 4'd0));
  assign byte_o       = flush_i ? (acc_q << (4'd8 - cnt_q)) : acc_shift;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= 8'h00;
      cnt_q <= 4'd0;
    end else if (flush_i) begin
      acc_q <= 8'h00;
      cnt_q <= 4'd0;
    end else if (sym_valid_i) begin
      if (cnt_sum == 4'd8) begin
        acc_q <= 8'h00;
        cnt_q <= 4'd0;
      end else begin
        acc_q <= acc_shift;
        cnt_q <= cnt_sum;
      end
    end
  end

endmodule

// File: rtl/demod_stream_proc.sv
// demod_stream_proc
//   Store-and-forward packet demodulator. Symbols of one packet are
//   hard-decided (BPSK/QPSK/16-QAM, mode latched on the first beat), packed
//   into bytes, buffered in an inferred RAM, then streamed out with the byte
//   count and a last flag.
//   Optional feature macro: DEMOD_STATS_EN adds o_pkt_count / o_drop_count.
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_tdata_valid/i_tdata   input symbol stream, i_tdata_last marks packet end
//   i_mode                  00 BPSK, 01 QPSK, 10 16-QAM, 11 treated as QPSK
//   o_tready                input ready (IDLE/RECV only)
//   i_tmanager_ready        downstream ready
//   o_tanswer_ready/_data/_data_last   output byte stream
//   o_packet_size_in_bytes  bytes stored for the current packet
//   o_pkt_count/o_drop_count (DEMOD_STATS_EN) sent packets / dropped overflow bytes
module demod_stream_proc
  import demod_stream_pkg::*;
#(
  parameter int SYM_W     = 8,
  parameter int OUT_DEPTH = 2048,
  parameter int SIZE_W    = 12,
  parameter int QAM_THR   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tdata_valid,
  input  logic [SYM_W-1:0]  i_tdata,
  input  logic              i_tdata_last,
  input  logic [1:0]        i_mode,
  output logic              o_tready,
  input  logic              i_tmanager_ready,
  output logic              o_tanswer_ready,
  output logic [7:0]        o_tanswer_data,
  output logic              o_tanswer_data_last,
`ifdef DEMOD_STATS_EN
  output logic [15:0]       o_pkt_count,
  output logic [15:0]       o_drop_count,
`endif
  output logic [SIZE_W-1:0] o_packet_size_in_bytes
);

  localparam int ADDR_W = $clog2(OUT_DEPTH);

  state_e            state_q;
  mode_e             mode_q;
  logic              tready_q;
  logic [SIZE_W-1:0] wr_cnt_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [SIZE_W-1:0] out_idx_q;
  logic [7:0]        ram_rd_q;
  logic              ans_valid_q;
  logic [7:0]        ans_data_q;
  logic              ans_last_q;

  logic [7:0] mem [OUT_DEPTH];

  logic       in_beat, out_hs, send_load, rd_en, room, wr_en, pk_valid;
  logic [7:0] pk_byte;
  mode_e      mode_eff;

  assign in_beat  = i_tdata_valid && tready_q;
  assign out_hs   = ans_valid_q && i_tmanager_ready;
  // The first beat of a packet is decided with the live mode input; later
  // beats use the latched copy so mid-packet mode changes have no effect.
  assign mode_eff = (state_q == IDLE) ? to_mode(i_mode) : mode_q;

  demod_stream_packer #(
    .SYM_W  (SYM_W),
    .QAM_THR(QAM_THR)
  ) u_packer (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .sym_valid_i (in_beat),
    .sym_i       (i_tdata),
    .mode_i      (mode_eff),
    .flush_i     (state_q == FLUSH),
    .byte_o      (pk_byte),
    .byte_valid_o(pk_valid)
  );

  // Bytes past the buffer depth are dropped; the packet is truncated.
  assign room  = (wr_cnt_q < SIZE_W'(OUT_DEPTH));
  assign wr_en = pk_valid && room;

  // ram_rd_q always holds the byte after the one presented on the output, so
  // an accepted byte can be replaced on the very next edge. It loads the
  // first byte in PREP, then again on entry to SEND and on every non-last
  // output handshake.
  assign send_load = (state_q == SEND) && (!ans_valid_q || (out_hs && !ans_last_q));
  assign rd_en     = (state_q == PREP) || send_load;

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_cnt_q[ADDR_W-1:0]] <= pk_byte;
    end
    if (rd_en) begin
      ram_rd_q <= mem[rd_addr_q];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_QPSK;
      tready_q    <= 1'b1;
      wr_cnt_q    <= '0;
      rd_addr_q   <= '0;
      out_idx_q   <= '0;
      ans_valid_q <= 1'b0;
      ans_data_q  <= 8'h00;
      ans_last_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && in_beat) begin
        wr_cnt_q <= '0;
      end else if (wr_en) begin
        wr_cnt_q <= wr_cnt_q + SIZE_W'(1);
      end

      if (rd_en) begin
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (in_beat) begin
            mode_q <= to_mode(i_mode);
            if (i_tdata_last) begin
              state_q  <= FLUSH;
              tready_q <= 1'b0;
            end else begin
              state_q <= RECV;
            end
          end
        end
        RECV: begin
          if (in_beat && i_tdata_last) begin
            state_q  <= FLUSH;
            tready_q <= 1'b0;
          end
        end
        FLUSH: begin
          state_q   <= PREP;
          rd_addr_q <= '0;
        end
        PREP: begin
          state_q <= SEND;
        end
        SEND: begin
          if (send_load) begin
            ans_valid_q <= 1'b1;
            ans_data_q  <= ram_rd_q;
            if (!ans_valid_q) begin
              out_idx_q  <= '0;
              ans_last_q <= (wr_cnt_q == SIZE_W'(1));
            end else begin
              out_idx_q  <= out_idx_q + SIZE_W'(1);
              // next index (out_idx+1) is last when it equals size-1
              ans_last_q <= (({1'b0, out_idx_q} + (SIZE_W+1)'(2)) == {1'b0, wr_cnt_q});
            end
          end else if (out_hs && ans_last_q) begin
            ans_valid_q <= 1'b0;
            ans_last_q  <= 1'b0;
            state_q     <= IDLE;
            tready_q    <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          tready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef DEMOD_STATS_EN
  logic [15:0] pkt_count_q, drop_count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_count_q  <= 16'h0000;
      drop_count_q <= 16'h0000;
    end else begin
      if (state_q == SEND && out_hs && ans_last_q && pkt_count_q != 16'hFFFF) begin
        pkt_count_q <= pkt_count_q + 16'h0001;
      end
      if (pk_valid && !room && drop_count_q != 16'hFFFF) begin
        drop_count_q <= drop_count_q + 16'h0001;
      end
    end
  end

  assign o_pkt_count  = pkt_count_q;
  assign o_drop_count = drop_count_q;
`endif

  assign o_tready               = tready_q;
  assign o_tanswer_ready        = ans_valid_q;
  assign o_tanswer_data         = ans_data_q;
  assign o_tanswer_data_last    = ans_last_q;
  assign o_packet_size_in_bytes = wr_cnt_q;

endmodule

// File: tb/tb_demod_stream_proc.sv
// tb_demod_stream_proc
//   Scoreboard bench for demod_stream_proc (OUT_DEPTH=4 so truncation is
//   reachable with short packets). Stimulus pushes hand-computed bytes into
//   a queue; a monitor pops and compares on every output handshake.
//   Define DEMOD_STATS_EN to also check the statistics counters.
module tb_demod_stream_proc;

  localparam int SIZE_W = 3;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_tdata_valid;
  logic [7:0]        i_tdata;
  logic              i_tdata_last;
  logic [1:0]        i_mode;
  logic              o_tready;
  logic              i_tmanager_ready;
  logic              o_tanswer_ready;
  logic [7:0]        o_tanswer_data;
  logic              o_tanswer_data_last;
  logic [SIZE_W-1:0] o_packet_size_in_bytes;
`ifdef DEMOD_STATS_EN
  logic [15:0]       o_pkt_count, o_drop_count;
`endif

  always #5 i_clk = ~i_clk;

  demod_stream_proc #(
    .SYM_W(8), .OUT_DEPTH(4), .SIZE_W(SIZE_W), .QAM_THR(4)
  ) dut (
    .i_clk                 (i_clk),
    .i_rst                 (i_rst),
    .i_tdata_valid         (i_tdata_valid),
    .i_tdata               (i_tdata),
    .i_tdata_last          (i_tdata_last),
    .i_mode                (i_mode),
    .o_tready              (o_tready),
    .i_tmanager_ready      (i_tmanager_ready),
    .o_tanswer_ready       (o_tanswer_ready),
    .o_tanswer_data        (o_tanswer_data),
    .o_tanswer_data_last   (o_tanswer_data_last),
`ifdef DEMOD_STATS_EN
    .o_pkt_count           (o_pkt_count),
    .o_drop_count          (o_drop_count),
`endif
    .o_packet_size_in_bytes(o_packet_size_in_bytes)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         size;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: toggle every cycle

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l, input int s);
    exp_t e;
    e.data = d;
    e.last = l;
    e.size = s;
    sb.push_back(e);
  endtask

  // Caller is 2 time units after a rising edge; returns at the same phase
  // after the edge that accepted the symbol.
  task automatic drive_sym(input logic [7:0] d, input logic l, input logic [1:0] m);
    i_tdata_valid = 1'b1;
    i_tdata       = d;
    i_tdata_last  = l;
    i_mode        = m;
    @(posedge i_clk);
    #2;
    i_tdata_valid = 1'b0;
    i_tdata_last  = 1'b0;
  endtask

  task automatic check_latency(input string nm);
    int k;
    for (k = 1; k <= 8; k++) begin
      @(posedge i_clk);
      #1;
      if (o_tanswer_ready) break;
    end
    #1;
    check(nm, k, 3);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      if (sb.size() == 0 && o_tready && !o_tanswer_ready) break;
      @(posedge i_clk);
      #2;
    end
    n_checks++;
    if (k == 200) begin
      n_fail++;
      $display("FAIL %s: drain timeout, got %0d bytes pending, required 0", nm, sb.size());
    end
  endtask

  // Downstream ready driver.
  initial begin
    i_tmanager_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #2;
      if (rdy_mode == 1) i_tmanager_ready = ~i_tmanager_ready;
      else               i_tmanager_ready = 1'b1;
    end
  end

  // Monitor: samples mid-cycle, when inputs and outputs are both settled.
  initial begin
    logic       pend;
    logic [7:0] pend_data;
    logic       pend_last;
    exp_t       e;
    pend = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("hold_valid", o_tanswer_ready, 1);
          check("hold_data", o_tanswer_data, pend_data);
          check("hold_last", o_tanswer_data_last, pend_last);
        end
        pend = 1'b0;
        if (o_tanswer_ready) begin
          check("tready_low_in_send", o_tready, 0);
          if (i_tmanager_ready) begin
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_byte: got 0x%0h, required none", o_tanswer_data);
            end else begin
              e = sb.pop_front();
              check("byte_data", o_tanswer_data, e.data);
              check("byte_last", o_tanswer_data_last, e.last);
              check("byte_size", o_packet_size_in_bytes, e.size);
              $display("byte 0x%02h last=%0b size=%0d (expected 0x%02h/%0b/%0d)",
                       o_tanswer_data, o_tanswer_data_last, o_packet_size_in_bytes,
                       e.data, e.last, e.size);
            end
          end else begin
            pend      = 1'b1;
            pend_data = o_tanswer_data;
            pend_last = o_tanswer_data_last;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] qam_pkt [6];
    logic [7:0] q12 [12];
    logic [7:0] q24 [24];
`ifdef DEMOD_STATS_EN
    logic [15:0] pkt_before;
`endif
    qam_pkt = '{8'h7C, 8'h21, 8'h88, 8'h11, 8'h80, 8'h4F};      // 0x70 0xF0 0xC6
    q24 = '{8'h1F, 8'hF1, 8'hFF, 8'h11,                          // 0x6C
            8'h11, 8'h1F, 8'hF1, 8'hFF,                          // 0x1B
            8'hFF, 8'hF1, 8'h1F, 8'h11,                          // 0xE4
            8'h1F, 8'h1F, 8'h1F, 8'h1F,                          // 0x55
            8'h11, 8'h11, 8'h11, 8'h11,                          // 0x00 (dropped)
            8'hFF, 8'hFF, 8'hFF, 8'hFF};                         // 0xFF (dropped)
    for (int i = 0; i < 12; i++) q12[i] = q24[i];

    i_rst = 1'b1;
    i_tdata_valid = 1'b0;
    i_tdata = 8'h00;
    i_tdata_last = 1'b0;
    i_mode = 2'b01;
    repeat (3) @(posedge i_clk);
    #2;
    check("rst_tready", o_tready, 1);
    check("rst_valid", o_tanswer_ready, 0);
    check("rst_data", o_tanswer_data, 0);
    check("rst_last", o_tanswer_data_last, 0);
    check("rst_size", o_packet_size_in_bytes, 0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #2;

    // QPSK, one full byte
    push_exp(8'h6C, 1'b1, 1);
    drive_sym(8'h1F, 1'b0, 2'b01);
    drive_sym(8'hF1, 1'b0, 2'b01);
    drive_sym(8'hFF, 1'b0, 2'b01);
    drive_sym(8'h11, 1'b1, 2'b01);
    check_latency("latency_qpsk");
    wait_idle("t1_qpsk");

    // 16-QAM; mode change on the second symbol must be ignored
    push_exp(8'h70, 1'b1, 1);
    drive_sym(8'h7C, 1'b0, 2'b10);
    drive_sym(8'h21, 1'b1, 2'b00);
    wait_idle("t2_qam16");

    // BPSK partial byte, zero padded
    push_exp(8'hA0, 1'b1, 1);
    drive_sym(8'h80, 1'b0, 2'b00);
    drive_sym(8'h10, 1'b0, 2'b00);
    drive_sym(8'h90, 1'b1, 2'b00);
    check_latency("latency_bpsk_pad");
    wait_idle("t3_bpsk");

    // Reserved mode behaves as QPSK
    push_exp(8'h6C, 1'b1, 1);
    drive_sym(8'h1F, 1'b0, 2'b11);
    drive_sym(8'hF1, 1'b0, 2'b11);
    drive_sym(8'hFF, 1'b0, 2'b11);
    drive_sym(8'h11, 1'b1, 2'b11);
    wait_idle("t3b_reserved");

    // Single-symbol packet: first and last beat at once
    push_exp(8'h80, 1'b1, 1);
    drive_sym(8'h80, 1'b1, 2'b00);
    check_latency("latency_single");
    wait_idle("t3c_single");

    // Overflow: 6 bytes into a 4-byte buffer
    push_exp(8'h6C, 1'b0, 4);
    push_exp(8'h1B, 1'b0, 4);
    push_exp(8'hE4, 1'b0, 4);
    push_exp(8'h55, 1'b1, 4);
    for (int i = 0; i < 24; i++) drive_sym(q24[i], (i == 23), 2'b01);
    wait_idle("t4_overflow");
`ifdef DEMOD_STATS_EN
    check("drop_count", o_drop_count, 2);
    pkt_before = o_pkt_count;
`endif

    // Back-pressure: ready toggles every cycle
    rdy_mode = 1;
    push_exp(8'h70, 1'b0, 3);
    push_exp(8'hF0, 1'b0, 3);
    push_exp(8'hC6, 1'b1, 3);
    for (int i = 0; i < 6; i++) drive_sym(qam_pkt[i], (i == 5), 2'b10);
    wait_idle("t5_backpressure");
    rdy_mode = 0;
    @(posedge i_clk);
    #2;
`ifdef DEMOD_STATS_EN
    check("pkt_count_inc", o_pkt_count, pkt_before + 16'd1);
`endif

    // Reset during SEND after the first of three bytes
    push_exp(8'h6C, 1'b0, 3);
    push_exp(8'h1B, 1'b0, 3);
    push_exp(8'hE4, 1'b1, 3);
    for (int i = 0; i < 12; i++) drive_sym(q12[i], (i == 11), 2'b01);
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        if (sb.size() == 2) break;
        @(posedge i_clk);
        #2;
      end
      check("t6_first_byte_seen", (k < 50), 1);
    end
    i_rst = 1'b1;
    @(posedge i_clk);
    #2;
    check("t6_rst_valid", o_tanswer_ready, 0);
    check("t6_rst_data", o_tanswer_data, 0);
    check("t6_rst_last", o_tanswer_data_last, 0);
    check("t6_rst_size", o_packet_size_in_bytes, 0);
    check("t6_rst_tready", o_tready, 1);
    i_rst = 1'b0;
    sb.delete();
    @(posedge i_clk);
    #2;
    push_exp(8'h70, 1'b0, 3);
    push_exp(8'hF0, 1'b0, 3);
    push_exp(8'hC6, 1'b1, 3);
    for (int i = 0; i < 6; i++) drive_sym(qam_pkt[i], (i == 5), 2'b10);
    wait_idle("t6_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
